// File: rtl/uart232_pkg.sv
// Shared UART link definitions: FSM states, default bit timing
// and line idle level for the transmitter and receiver.
package uart232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int CLKS_PER_BIT_DEF = 1041;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/tx232_byte_tx_if.sv
// Byte valid/ready handshake between a producer
// and the UART transmitter.
interface tx232_byte_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart232_baud_cnt.sv
// Bit-period counter: wraps every CLKS_PER_BIT clk, flags the
// last cycle of a bit and a registered second-half indicator.
module uart232_baud_cnt
  import uart232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end,
  output logic second_half
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign bit_end = en & (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = bit_end ? '0 : cnt + CW'(1);
  end

  // second_half tracks cnt so it flips on bit boundaries
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      second_half <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      second_half <= (cnt_nxt >= HALF);
    end
  end

endmodule

// File: rtl/tx232_byte_tx.sv
// UART transmitter: one byte per handshake, start/data/
// parity/stop framing, zero-gap back-to-back frames.
module tx232_byte_tx
  import uart232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  tx232_byte_tx_if.slave    bus,
  output logic              txsdo,
  output logic              txck,
  output logic              tx_busy
);

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [3:0]           idx;
  logic [3:0]           idx_nxt;
  logic [DATA_BITS-1:0] sreg;
  logic [DATA_BITS-1:0] sreg_nxt;
  logic                 par;
  logic                 par_nxt;
  logic                 txsdo_nxt;
  logic                 busy_nxt;
  logic                 bit_end;
  logic                 half;
  logic                 accept;
  logic                 stop_last;
  logic                 last_data;

  assign stop_last = (idx == 4'(STOP_BITS - 1));
  assign last_data = (idx == 4'(DATA_BITS - 1));

  assign bus.tx_ready = (state == IDLE) |
    ((state == STOP) & stop_last & bit_end);
  assign accept = bus.tx_valid & bus.tx_ready;

  uart232_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .en         (state != IDLE),
    .clr        (state == IDLE),
    .bit_end    (bit_end),
    .second_half(half)
  );

  assign txck = half;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sreg_nxt  = sreg;
    par_nxt   = par;
    txsdo_nxt = txsdo;
    busy_nxt  = tx_busy;
    unique case (state)
      IDLE: begin
        txsdo_nxt = UART_IDLE_LVL;
        busy_nxt  = 1'b0;
      end
      START: if (bit_end) begin
        state_nxt = DATA;
        idx_nxt   = '0;
        txsdo_nxt = sreg[0];
      end
      DATA: if (bit_end) begin
        if (!last_data) begin
          idx_nxt   = idx + 4'd1;
          sreg_nxt  = sreg >> 1;
          txsdo_nxt = sreg[1];
        end else if (PARITY_EN != 0) begin
          state_nxt = PARITY;
          txsdo_nxt = par;
        end else begin
          state_nxt = STOP;
          idx_nxt   = '0;
          txsdo_nxt = UART_IDLE_LVL;
        end
      end
      PARITY: if (bit_end) begin
        state_nxt = STOP;
        idx_nxt   = '0;
        txsdo_nxt = UART_IDLE_LVL;
      end
      STOP: if (bit_end) begin
        if (!stop_last) begin
          idx_nxt = idx + 4'd1;
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          txsdo_nxt = UART_IDLE_LVL;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // accept overrides STOP->IDLE so the next start bit follows directly
    if (accept) begin
      state_nxt = START;
      idx_nxt   = '0;
      sreg_nxt  = bus.tx_data;
      par_nxt   = (^bus.tx_data) ^ (PARITY_ODD != 0);
      txsdo_nxt = ~UART_IDLE_LVL;
      busy_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      sreg    <= '0;
      par     <= 1'b0;
      txsdo   <= UART_IDLE_LVL;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      sreg    <= sreg_nxt;
      par     <= par_nxt;
      txsdo   <= txsdo_nxt;
      tx_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tx232_byte_tx.sv
// Directed vector bench for the UART transmitter: 8N1, even,
// odd parity at 16 clk/bit and 8N1 at 1041 clk/bit.
module tb_tx232_byte_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld [4];
  logic [7:0] dat [4];
  logic       rdy [4];
  logic       sdo [4];
  logic       ck  [4];
  logic       busy[4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tx232_byte_tx_if #(.DATA_BITS(8)) if0 ();
  tx232_byte_tx_if #(.DATA_BITS(8)) if1 ();
  tx232_byte_tx_if #(.DATA_BITS(8)) if2 ();
  tx232_byte_tx_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign if3.tx_valid = vld[3];
  assign if0.tx_data  = dat[0];
  assign if1.tx_data  = dat[1];
  assign if2.tx_data  = dat[2];
  assign if3.tx_data  = dat[3];
  assign rdy[0] = if0.tx_ready;
  assign rdy[1] = if1.tx_ready;
  assign rdy[2] = if2.tx_ready;
  assign rdy[3] = if3.tx_ready;

  tx232_byte_tx #(.CLKS_PER_BIT(16)) d0 (
    .clk(clk), .rst(rst), .bus(if0.slave),
    .txsdo(sdo[0]), .txck(ck[0]), .tx_busy(busy[0])
  );
  tx232_byte_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1),
                  .PARITY_ODD(0)) d1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .txsdo(sdo[1]), .txck(ck[1]), .tx_busy(busy[1])
  );
  tx232_byte_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1),
                  .PARITY_ODD(1)) d2 (
    .clk(clk), .rst(rst), .bus(if2.slave),
    .txsdo(sdo[2]), .txck(ck[2]), .tx_busy(busy[2])
  );
  tx232_byte_tx #(.CLKS_PER_BIT(1041)) d3 (
    .clk(clk), .rst(rst), .bus(if3.slave),
    .txsdo(sdo[3]), .txck(ck[3]), .tx_busy(busy[3])
  );

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [11:0] bits;
    int         nbits;
    string      name;
  } vec_t;

  vec_t vt[11];

  function automatic int cpb_of(input int d);
    return (d == 3) ? 1041 : 16;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic start_tx(input int d,
                          input logic [7:0] data,
                          input bit keep,
                          input logic [7:0] nxt,
                          input string name);
    int n = 0;
    @(negedge clk);
    dat[d] = data;
    vld[d] = 1'b1;
    while (rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, 32'(rdy[d]), 32'd1);
    chk({name, " idle"}, 32'(sdo[d]), 32'd1);
    @(posedge clk);
    #1;
    if (keep) dat[d] = nxt;
    else vld[d] = 1'b0;
  endtask

  // bit k spans samples k*cpb..k*cpb+cpb-1 after the accept edge
  task automatic capture(input int d,
                         input logic [11:0] bits,
                         input int nbits,
                         input string name);
    int cpb;
    int bad_bits = 0;
    int busy_low = 0;
    int nrdy = 0;
    int rdy_at = -1;
    cpb = cpb_of(d);
    for (int b = 0; b < nbits; b++) begin
      bit bad = 1'b0;
      for (int i = 0; i < cpb; i++) begin
        @(negedge clk);
        if (sdo[d] !== bits[b]) bad = 1'b1;
        if (ck[d] !== (i >= cpb / 2)) bad = 1'b1;
        if (busy[d] !== 1'b1) busy_low++;
        if (rdy[d] === 1'b1) begin
          nrdy++;
          rdy_at = b * cpb + i;
        end
      end
      if (bad) bad_bits |= (1 << b);
    end
    chk({name, " bits"}, bad_bits, 0);
    chk({name, " busy"}, busy_low, 0);
    chk({name, " rdy_n"}, nrdy, 1);
    chk({name, " rdy_at"}, rdy_at, nbits * cpb - 1);
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
  endtask

  task automatic end_idle(input int d,
                          input string name);
    @(negedge clk);
    chk({name, " end"}, {30'd0, sdo[d], busy[d]},
        32'b10);
  endtask

  initial begin
    int idle_bad;
    vt[0]  = '{0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0},
               10, "8n1_55"};
    vt[1]  = '{0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0},
               10, "8n1_00"};
    vt[2]  = '{0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0},
               10, "8n1_ff"};
    vt[3]  = '{1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0},
               11, "8e1_07"};
    vt[4]  = '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0},
               11, "8o1_07"};
    vt[5]  = '{1, 8'h00, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0},
               11, "8e1_00"};
    vt[6]  = '{2, 8'h00, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0},
               11, "8o1_00"};
    vt[7]  = '{1, 8'hB3, {1'b0, 1'b1, 1'b1, 8'hB3, 1'b0},
               11, "8e1_b3"};
    vt[8]  = '{3, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0},
               10, "slow_00"};
    vt[9]  = '{3, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0},
               10, "slow_ff"};
    vt[10] = '{3, 8'h5A, {2'b00, 1'b1, 8'h5A, 1'b0},
               10, "slow_5a"};
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end

    // reset held with a pending request
    rst    = 1'b0;
    vld[0] = 1'b1;
    dat[0] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset", {28'd0, sdo[0], ck[0], busy[0], rdy[0]},
          32'b1001);
    end
    vld[0] = 1'b0;
    rst    = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sdo[0] !== 1'b1 || busy[0] !== 1'b0)
        idle_bad++;
    end
    chk("post_reset_idle", idle_bad, 0);

    for (int v = 0; v < 11; v++) begin
      start_tx(vt[v].d, vt[v].data, 1'b0, 8'h00,
               vt[v].name);
      capture(vt[v].d, vt[v].bits, vt[v].nbits,
              vt[v].name);
      end_idle(vt[v].d, vt[v].name);
    end

    // back-to-back with tx_valid held across both frames
    start_tx(0, 8'hA5, 1'b1, 8'h3C, "b2b");
    capture(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, "b2b_a5");
    capture(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, "b2b_3c");
    end_idle(0, "b2b");

    // reset in data bit 3 of 0xF0 (a 0 on the line)
    start_tx(0, 8'hF0, 1'b0, 8'h00, "mid_rst");
    repeat (4 * 16 + 5) @(negedge clk);
    chk("mid_rst pre", {31'd0, sdo[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst post",
        {28'd0, sdo[0], busy[0], rdy[0], ck[0]},
        32'b1010);
    rst = 1'b1;
    start_tx(0, 8'h81, 1'b0, 8'h00, "after_rst");
    capture(0, {2'b00, 1'b1, 8'h81, 1'b0}, 10,
            "after_rst");
    end_idle(0, "after_rst");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
